axil_cmd_master: RTL and testbench

- Converts a simple single-outstanding command/response port into AXI4-Lite master transactions on an axil_if.src modport.
- Used by internal sequencers and debug logic to access AXI-Lite register slaves (axil_if.snk endpoints) without hand-built channel handshakes.
- Handles one transaction at a time, with registered channel outputs and a hang-detection timeout.

---
 rtl/axil_pkg.sv | 20 ++
 rtl/axil_if.sv | 35 +++
 rtl/axil_cmd_master.sv | 171 +++++++++++++++++
 tb/tb_axil_cmd_master.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite constants and the command-master FSM state type.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    StIdle,
    StWrAwW,
    StWrB,
    StRdAr,
    StRdR,
    StRsp
  } cmd_state_e;

endpackage

// File: rtl/axil_if.sv
// AXI4-Lite channel bundle; src is the master side, snk the slave side.
interface axil_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport src (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport snk (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_cmd_master.sv
// Single-outstanding command/response port to AXI4-Lite master bridge with
// registered channel outputs and a sticky hang-detection timeout.
module axil_cmd_master
  import axil_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter logic [2:0]  PROT           = PROT_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    busy,
  output logic                    timeout,
  axil_if.src                     m_axil
);

  localparam int unsigned CntW    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] TmoMax  = CntW'(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam bit              TmoEn   = (TIMEOUT_CYCLES != 0);

  cmd_state_e                state_q;
  logic                      awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
  logic                      aw_done_q, w_done_q;
  logic                      rsp_valid_q, write_q, timeout_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q, rdata_q;
  logic [DATA_WIDTH/8-1:0]   wstrb_q;
  logic [1:0]                resp_q;
  logic [CntW-1:0]           tmo_cnt_q;

  logic aw_hs, w_hs, waiting;

  always_comb begin
    aw_hs   = awvalid_q & m_axil.awready;
    w_hs    = wvalid_q & m_axil.wready;
    waiting = (state_q == StWrAwW) || (state_q == StWrB) ||
              (state_q == StRdAr) || (state_q == StRdR);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= StIdle;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      write_q     <= 1'b0;
      timeout_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      wstrb_q     <= '0;
      resp_q      <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      // Counter saturates at the limit; the transaction itself keeps waiting.
      if (TmoEn && waiting && (tmo_cnt_q != TmoMax)) begin
        tmo_cnt_q <= tmo_cnt_q + CntW'(1);
        if (tmo_cnt_q == TmoLast) timeout_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            wstrb_q   <= cmd_wstrb;
            write_q   <= cmd_write;
            timeout_q <= 1'b0;
            tmo_cnt_q <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            if (cmd_write) begin
              state_q   <= StWrAwW;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state_q   <= StRdAr;
              arvalid_q <= 1'b1;
            end
          end
        end
        StWrAwW: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
            state_q   <= StWrB;
            bready_q  <= 1'b1;
            tmo_cnt_q <= '0;
          end
        end
        StWrB: begin
          if (m_axil.bvalid && bready_q) begin
            resp_q      <= m_axil.bresp;
            rdata_q     <= '0;
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= StRsp;
          end
        end
        StRdAr: begin
          if (arvalid_q && m_axil.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StRdR;
            tmo_cnt_q <= '0;
          end
        end
        StRdR: begin
          if (m_axil.rvalid && rready_q) begin
            rdata_q     <= m_axil.rdata;
            resp_q      <= m_axil.rresp;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= StRsp;
          end
        end
        StRsp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign timeout   = timeout_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = write_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;

  assign m_axil.awaddr  = addr_q;
  assign m_axil.awprot  = PROT;
  assign m_axil.awvalid = awvalid_q;
  assign m_axil.wdata   = wdata_q;
  assign m_axil.wstrb   = wstrb_q;
  assign m_axil.wvalid  = wvalid_q;
  assign m_axil.bready  = bready_q;
  assign m_axil.araddr  = addr_q;
  assign m_axil.arprot  = PROT;
  assign m_axil.arvalid = arvalid_q;
  assign m_axil.rready  = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed and randomized checks of axil_cmd_master against a stalling AXI-Lite slave model.
module tb_axil_cmd_master;
  import axil_pkg::*;

  localparam int unsigned NONE = 32'hFFFF_FFFF;

  logic        aclk;
  logic        areset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        busy, timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned cyc = 0;

  axil_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) axil ();

  axil_cmd_master #(
    .DATA_WIDTH    (32),
    .ADDR_WIDTH    (32),
    .PROT          (3'b000),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .aclk     (aclk),
    .areset   (areset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata),
    .rsp_resp (rsp_resp),
    .busy     (busy),
    .timeout  (timeout),
    .m_axil   (axil)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  // Slave: each ready rises once its valid has waited cfg_*_stall cycles;
  // B/R come back stall+1 cycles after bready/rready is seen.
  int unsigned cfg_aw_stall = 0, cfg_w_stall = 0, cfg_b_stall = 0;
  int unsigned cfg_ar_stall = 0, cfg_r_stall = 0;
  logic [1:0]  cfg_bresp = RESP_OKAY, cfg_rresp = RESP_OKAY;
  int unsigned aw_seen, w_seen, ar_seen, b_seen, r_seen;
  logic        aw_got, w_got, rd_pending;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;
  int unsigned aw_hs_cyc, w_hs_cyc, ar_hs_cyc;
  logic [31:0] slv_mem [int unsigned];

  assign axil.awready = (aw_seen >= cfg_aw_stall);
  assign axil.wready  = (w_seen >= cfg_w_stall);
  assign axil.arready = (ar_seen >= cfg_ar_stall);

  always @(posedge aclk) begin
    if (areset) begin
      aw_seen <= 0; w_seen <= 0; ar_seen <= 0; b_seen <= 0; r_seen <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; rd_pending <= 1'b0;
      axil.bvalid <= 1'b0; axil.rvalid <= 1'b0;
      axil.bresp <= 2'b00; axil.rresp <= 2'b00; axil.rdata <= '0;
    end else begin
      if (axil.awvalid && axil.awready) begin
        aw_got <= 1'b1; cap_awaddr <= axil.awaddr; aw_seen <= 0; aw_hs_cyc <= cyc;
      end else if (axil.awvalid) aw_seen <= aw_seen + 1;
      if (axil.wvalid && axil.wready) begin
        w_got <= 1'b1; cap_wdata <= axil.wdata; cap_wstrb <= axil.wstrb; w_seen <= 0;
        w_hs_cyc <= cyc;
      end else if (axil.wvalid) w_seen <= w_seen + 1;
      if (aw_got && w_got && axil.bready && !axil.bvalid) begin
        if (b_seen >= cfg_b_stall) begin
          axil.bvalid <= 1'b1; axil.bresp <= cfg_bresp;
        end else b_seen <= b_seen + 1;
      end
      if (axil.bvalid && axil.bready) begin
        logic [31:0] word;
        word = slv_mem.exists(cap_awaddr >> 2) ? slv_mem[cap_awaddr >> 2] : 32'h0;
        for (int b = 0; b < 4; b++) if (cap_wstrb[b]) word[8*b +: 8] = cap_wdata[8*b +: 8];
        slv_mem[cap_awaddr >> 2] = word;
        axil.bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_seen <= 0;
      end
      if (axil.arvalid && axil.arready) begin
        rd_pending <= 1'b1; cap_araddr <= axil.araddr; ar_seen <= 0; ar_hs_cyc <= cyc;
      end else if (axil.arvalid) ar_seen <= ar_seen + 1;
      if (rd_pending && axil.rready && !axil.rvalid) begin
        if (r_seen >= cfg_r_stall) begin
          axil.rvalid <= 1'b1; axil.rresp <= cfg_rresp;
          axil.rdata  <= slv_mem.exists(cap_araddr >> 2) ? slv_mem[cap_araddr >> 2] : 32'h0;
        end else r_seen <= r_seen + 1;
      end
      if (axil.rvalid && axil.rready) begin
        axil.rvalid <= 1'b0; rd_pending <= 1'b0; r_seen <= 0;
      end
    end
  end

  // Channel monitor, restarted on every command accept.
  int unsigned mon_awv, mon_wv, mon_brdy_cyc;
  always @(posedge aclk) begin
    if (cmd_valid && cmd_ready) begin
      mon_awv <= 0; mon_wv <= 0; mon_brdy_cyc <= NONE;
    end else begin
      if (axil.awvalid) mon_awv <= mon_awv + 1;
      if (axil.wvalid) mon_wv <= mon_wv + 1;
      if (axil.bready && mon_brdy_cyc == NONE) mon_brdy_cyc <= cyc;
    end
  end

  // Reference memory: word address -> value, default 0.
  logic [31:0] ref_mem [int unsigned];

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a >> 2) ? ref_mem[a >> 2] : 32'h0;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    ref_mem[a >> 2] = (ref_read(a) & ~mask) | (d & mask);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called and returns just after a falling edge.
  task automatic start_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input bit keep, output int unsigned t_acc);
    bit ok = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    t_acc = cyc;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready === 1'b1) begin
        ok = 1; t_acc = cyc; break;
      end
      @(negedge aclk);
    end
    chk("cmd_accept", ok, 1);
    @(negedge aclk);
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic finish_rsp(input logic w, input logic [31:0] exp_rd, input logic [1:0] exp_resp,
                            input int unsigned t_acc, input int unsigned exp_lat,
                            input int unsigned rdy_dly, output int unsigned t_hs);
    bit got = 0, cr_bad = 0, unstable = 0;
    for (int i = 0; i < 60; i++) begin
      cr_bad |= (cmd_ready !== 1'b0);
      if (rsp_valid === 1'b1) begin
        got = 1; break;
      end
      @(negedge aclk);
    end
    chk("rsp_wait", got, 1);
    chk("rsp_latency", cyc - t_acc, exp_lat);
    chk("rsp_write", rsp_write, w);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_resp", rsp_resp, exp_resp);
    chk("busy_in_rsp", busy, 1);
    for (int k = 0; k < int'(rdy_dly); k++) begin
      @(negedge aclk);
      unstable |= (rsp_valid !== 1'b1) || (rsp_rdata !== exp_rd) || (rsp_resp !== exp_resp) ||
                  (rsp_write !== w);
      cr_bad |= (cmd_ready !== 1'b0);
    end
    chk("rsp_stable", unstable, 0);
    chk("cmd_ready_low_while_busy", cr_bad, 0);
    rsp_ready = 1'b1;
    t_hs = cyc;
    @(negedge aclk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("cmd_ready_after_rsp", cmd_ready, 1);
  endtask

  task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int unsigned aws, input int unsigned ws,
                         input int unsigned bs, input int unsigned ars, input int unsigned rs,
                         input logic [1:0] br, input logic [1:0] rr, input int unsigned rdy);
    int unsigned t_acc, t_hs, lat, m;
    logic [31:0] exp_rd;
    cfg_aw_stall = aws; cfg_w_stall = ws; cfg_b_stall = bs;
    cfg_ar_stall = ars; cfg_r_stall = rs; cfg_bresp = br; cfg_rresp = rr;
    m = (aws > ws) ? aws : ws;
    exp_rd = w ? 32'h0 : ref_read(a);
    lat = w ? 4 + m + bs : 4 + ars + rs;
    start_cmd(w, a, d, s, 1'b0, t_acc);
    finish_rsp(w, exp_rd, w ? br : rr, t_acc, lat, rdy, t_hs);
    if (w) begin
      chk("aw_hs_cycle", aw_hs_cyc, t_acc + 1 + aws);
      chk("w_hs_cycle", w_hs_cyc, t_acc + 1 + ws);
      chk("awvalid_cycles", mon_awv, aws + 1);
      chk("wvalid_cycles", mon_wv, ws + 1);
      chk("bready_first_cycle", mon_brdy_cyc, t_acc + 2 + m);
      chk("awaddr", cap_awaddr, a);
      chk("wdata", cap_wdata, d);
      chk("wstrb", cap_wstrb, s);
      ref_write(a, d, s);
    end else begin
      chk("ar_hs_cycle", ar_hs_cyc, t_acc + 1 + ars);
      chk("araddr", cap_araddr, a);
    end
    chk("no_timeout", timeout, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t_acc, t_acc2, t_hs;
    bit bad, seen;
    areset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge aclk);
    chk("rst_awvalid", axil.awvalid, 0);
    chk("rst_wvalid", axil.wvalid, 0);
    chk("rst_arvalid", axil.arvalid, 0);
    chk("rst_bready", axil.bready, 0);
    chk("rst_rready", axil.rready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    areset = 1'b0;
    @(negedge aclk);
    chk("idle_cmd_ready", cmd_ready, 1);

    // Basic write, then write+read of 0x14 with a SLVERR read response.
    run_txn(1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, RESP_OKAY, RESP_OKAY, 0);
    run_txn(1, 32'h14, 32'hCAFE_0001, 4'hF, 0, 0, 0, 0, 0, RESP_OKAY, RESP_OKAY, 0);
    run_txn(0, 32'h14, 32'h0, 4'h0, 0, 0, 0, 0, 0, RESP_OKAY, RESP_SLVERR, 0);
    chk("read_value_0x14", rsp_rdata, 32'hCAFE_0001);
    // awready late by 3, wready immediate.
    run_txn(1, 32'h18, 32'h1234_5678, 4'h5, 3, 0, 0, 0, 0, RESP_DECERR, RESP_OKAY, 0);

    // Response back-pressure with cmd_valid held high the whole time.
    cfg_aw_stall = 0; cfg_w_stall = 0; cfg_b_stall = 0; cfg_ar_stall = 0; cfg_r_stall = 0;
    cfg_rresp = RESP_OKAY;
    start_cmd(0, 32'h10, 32'h0, 4'h0, 1'b1, t_acc);
    finish_rsp(0, ref_read(32'h10), RESP_OKAY, t_acc, 4, 5, t_hs);
    start_cmd(0, 32'h10, 32'h0, 4'h0, 1'b0, t_acc2);
    chk("b2b_accept_cycle", t_acc2, t_hs + 1);
    finish_rsp(0, ref_read(32'h10), RESP_OKAY, t_acc2, 4, 0, t_hs);

    // Timeout with arready never asserted, then reset.
    cfg_ar_stall = 1000;
    start_cmd(0, 32'h20, 32'h0, 4'h0, 1'b0, t_acc);
    bad = 0;
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) @(negedge aclk);
      bad |= (timeout !== 1'b0);
    end
    chk("timeout_not_early", bad, 0);
    @(negedge aclk);
    chk("timeout_set", timeout, 1);
    chk("timeout_arvalid_held", axil.arvalid, 1);
    repeat (4) @(negedge aclk);
    chk("timeout_sticky", timeout, 1);
    chk("timeout_still_waiting", busy, 1);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    chk("tmo_rst_timeout", timeout, 0);
    chk("tmo_rst_arvalid", axil.arvalid, 0);
    chk("tmo_rst_cmd_ready", cmd_ready, 1);
    cfg_ar_stall = 0;

    // Reset while waiting for B.
    cfg_b_stall = 6;
    start_cmd(1, 32'h1C, 32'hA5A5_A5A5, 4'hF, 1'b0, t_acc);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (axil.bready === 1'b1) begin
        seen = 1; break;
      end
      @(negedge aclk);
    end
    chk("wrb_reached", seen, 1);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    chk("wrb_rst_awvalid", axil.awvalid, 0);
    chk("wrb_rst_wvalid", axil.wvalid, 0);
    chk("wrb_rst_arvalid", axil.arvalid, 0);
    chk("wrb_rst_bready", axil.bready, 0);
    chk("wrb_rst_rready", axil.rready, 0);
    chk("wrb_rst_rsp_valid", rsp_valid, 0);
    chk("wrb_rst_busy", busy, 0);
    chk("wrb_rst_cmd_ready", cmd_ready, 1);

    // Randomized traffic over a small address window.
    for (int n = 0; n < 24; n++) begin
      logic        w;
      logic [31:0] a;
      w = 1'($urandom_range(0, 1));
      a = 32'h100 + 32'($urandom_range(0, 7) << 2);
      run_txn(w, a, $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 4), $urandom_range(0, 4),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
